// File: rtl/uni2bin_window.sv
// uni2bin_window: decodes a unary bitstream into a count over 2^INWD enabled samples, valid/ready output.
// Optional macro BIPOLAR_EN selects bipolar decode (2x - 2^INWD). Rev 1.0
`default_nettype none

module uni2bin_window #(
  parameter int INWD  = 4,
  parameter int OUTWD = INWD + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             start,
  input  logic             cont,
  input  logic             bitIn,
  output logic             busy,
  output logic             outValid,
  input  logic             outReady,
  output logic [OUTWD-1:0] outBin,
  output logic             ovf
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic [OUTWD-1:0] BIAS = OUTWD'(2 ** INWD);

  state_t          state;
  logic [INWD-1:0] cnt;
  logic [INWD:0]   acc;
  logic [INWD:0]   sum;
  logic            last_sample;

  // The final sample is folded in directly so the result is ready on the window-end edge.
  assign sum         = acc + {{INWD{1'b0}}, bitIn};
  assign last_sample = (cnt == {INWD{1'b1}});

  function automatic logic [OUTWD-1:0] decode(input logic [INWD:0] x);
    logic [OUTWD-1:0] ext;
    ext = {{(OUTWD-INWD-1){1'b0}}, x};
`ifdef BIPOLAR_EN
    return (ext << 1) - BIAS;
`else
    return ext;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      outBin   <= '0;
      outValid <= 1'b0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (outValid && outReady) begin
        outValid <= 1'b0;
      end

      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            state <= ACCUM;
            busy  <= 1'b1;
            cnt   <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
          end
        end

        ACCUM: begin
          busy <= 1'b1;
          if (enable) begin
            cnt <= cnt + 1'b1;
            if (last_sample) begin
              outBin   <= decode(sum);
              outValid <= 1'b1;
              acc      <= '0;
              // Overwriting a result nobody took this edge is the only overflow case.
              if (outValid && !outReady) begin
                ovf <= 1'b1;
              end
              if (!cont) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              acc <= sum;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uni2bin_window.sv
// tb_uni2bin_window: directed self-checking bench for uni2bin_window (INWD=4, OUTWD=6).
`default_nettype none

module tb_uni2bin_window;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       bitIn = 1'b0;
  logic       outReady = 1'b1;
  logic       busy;
  logic       outValid;
  logic [5:0] outBin;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  uni2bin_window #(.INWD(4), .OUTWD(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .start    (start),
    .cont     (cont),
    .bitIn    (bitIn),
    .busy     (busy),
    .outValid (outValid),
    .outReady (outReady),
    .outBin   (outBin),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected decode of a count k.
  function automatic logic [5:0] dec(input int k);
`ifdef BIPOLAR_EN
    return 6'(2 * k - 16);
`else
    return 6'(k);
`endif
  endfunction

  // 4-bit Sobol (first dimension = bit-reversed index) comparator stream for k/16.
  function automatic logic sobol_bit(input int i, input int k);
    logic [3:0] idx;
    logic [3:0] rev;
    idx = i[3:0];
    rev = {idx[0], idx[1], idx[2], idx[3]};
    return (int'(rev) < k);
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic window(input int k);
    for (int i = 0; i < 16; i++) begin
      enable = 1'b1;
      bitIn  = sobol_bit(i, k);
      tick();
    end
    enable = 1'b0;
    bitIn  = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_valid", outValid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bin", outBin, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    tick();

    // 1: single window of 5/16
    do_start();
    chk("t1_busy_start", busy, 1);
    for (int i = 0; i < 16; i++) begin
      enable = 1'b1;
      bitIn  = sobol_bit(i, 5);
      tick();
      if (i == 14) chk("t1_no_early_valid", outValid, 0);
    end
    enable = 1'b0;
    bitIn  = 1'b0;
    chk("t1_valid", outValid, 1);
    chk("t1_bin", outBin, dec(5));
    chk("t1_busy_done", busy, 0);
    tick();
    chk("t1_valid_drop", outValid, 0);
    chk("t1_bin_hold", outBin, dec(5));

    // 2: all-ones and all-zeros windows
    do_start();
    window(16);
    chk("t2_ones", outBin, dec(16));
    tick();
    do_start();
    window(0);
    chk("t2_zeros", outBin, dec(0));
    chk("t2_zeros_valid", outValid, 1);
    tick();

    // 3: enable gating; bits on disabled cycles must be ignored
    outReady = 1'b0;
    do_start();
    for (int j = 0; j < 32; j++) begin
      enable = (j % 2 == 0);
      bitIn  = (j % 2 != 0);
      tick();
      if (j == 29) chk("t3a_not_done", outValid, 0);
    end
    chk("t3a_valid", outValid, 1);
    chk("t3a_bin", outBin, dec(0));
    outReady = 1'b1;
    enable   = 1'b0;
    bitIn    = 1'b0;
    tick();
    outReady = 1'b0;
    do_start();
    for (int j = 0; j < 32; j++) begin
      enable = (j % 2 != 0);
      bitIn  = (j % 2 != 0);
      tick();
      if (j == 30) begin
        chk("t3b_busy", busy, 1);
        chk("t3b_not_done", outValid, 0);
      end
    end
    chk("t3b_valid", outValid, 1);
    chk("t3b_bin", outBin, dec(16));
    chk("t3b_ovf", ovf, 0);
    enable   = 1'b0;
    bitIn    = 1'b0;
    outReady = 1'b1;
    tick();

    // 4: continuous mode, back-to-back windows of 9/16
    cont = 1'b1;
    do_start();
    for (int w = 0; w < 3; w++) begin
      if (w == 2) cont = 1'b0;
      for (int i = 0; i < 16; i++) begin
        enable = 1'b1;
        bitIn  = sobol_bit(i, 9);
        tick();
        if (i == 0 && w > 0) chk("t4_pulse_drop", outValid, 0);
      end
      chk("t4_valid", outValid, 1);
      chk("t4_bin", outBin, dec(9));
      chk("t4_busy", busy, (w < 2) ? 1 : 0);
    end
    enable = 1'b0;
    bitIn  = 1'b0;
    tick();

    // 5: overflow when a result is overwritten unconsumed
    outReady = 1'b0;
    cont     = 1'b1;
    do_start();
    window(3);
    chk("t5_first_bin", outBin, dec(3));
    chk("t5_first_ovf", ovf, 0);
    cont = 1'b0;
    window(7);
    chk("t5_bin", outBin, dec(7));
    chk("t5_valid", outValid, 1);
    chk("t5_ovf", ovf, 1);
    outReady = 1'b1;
    tick();
    chk("t5_valid_drop", outValid, 0);
    chk("t5_ovf_sticky", ovf, 1);
    do_start();
    chk("t5_ovf_clear", ovf, 0);
    outReady = 1'b0;
    window(12);
    chk("t5_last_bin", outBin, dec(12));

    // 6: asynchronous reset mid-window
    do_start();
    for (int i = 0; i < 8; i++) begin
      enable = 1'b1;
      bitIn  = 1'b1;
      tick();
    end
    chk("t6_pre_valid", outValid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", outValid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_bin", outBin, 0);
    enable = 1'b0;
    bitIn  = 1'b0;
    tick();
    rst_n    = 1'b1;
    outReady = 1'b1;
    tick();
    do_start();
    window(5);
    chk("t6_clean_bin", outBin, dec(5));
    chk("t6_clean_valid", outValid, 1);
    chk("t6_clean_ovf", ovf, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
